// File: rtl/seq1010_scan_scheduler.sv
// seq1010_scan_scheduler: round-robin sharing of one external 1010 detector between
// two word requesters; each granted word is shifted in MSB-first and its hits counted.
module seq1010_scan_scheduler #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        req,
    input  logic [WORD_W-1:0] req_word0,
    input  logic [WORD_W-1:0] req_word1,
    output logic [1:0]        ack,
    output logic              det_rstn,
    output logic              det_data,
    input  logic              det_hit,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [CNT_W-1:0]  res_count,
    output logic              busy
);
    localparam int IW = $clog2(WORD_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(WORD_W - 1);
    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, RESULT} state_t;
    state_t state, state_nxt;
    logic [WORD_W-1:0] sreg;
    logic [IW-1:0] bit_idx;
    logic [CNT_W-1:0] hit_cnt, hit_nxt;
    logic grant, last_grant, pick, sample, start;
    always_comb begin
        start = state == IDLE && req != 2'b00;
        pick = (req == 2'b11) ? ~last_grant : req[1];
        // the first SHIFT cycle only reflects the cleared detector, so it is not counted
        sample = (state == SHIFT && bit_idx != '0) || state == DRAIN;
        hit_nxt = (sample && det_hit && hit_cnt != '1) ? hit_cnt + 1'b1 : hit_cnt;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CLR : IDLE;
            CLR:     state_nxt = SHIFT;
            SHIFT:   state_nxt = (bit_idx == LAST_BIT) ? DRAIN : SHIFT;
            DRAIN:   state_nxt = RESULT;
            RESULT:  state_nxt = res_ready ? IDLE : RESULT;
            default: state_nxt = IDLE;
        endcase
    end
    assign res_valid = state == RESULT;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            ack <= 2'b00;
            det_rstn <= 1'b0;
            det_data <= 1'b0;
            res_id <= 1'b0;
            res_count <= '0;
            last_grant <= 1'b1;
            grant <= 1'b0;
            sreg <= '0;
            bit_idx <= '0;
            hit_cnt <= '0;
        end else begin
            state <= state_nxt;
            ack <= start ? (pick ? 2'b10 : 2'b01) : 2'b00;
            det_rstn <= state_nxt != CLR;
            det_data <= (state_nxt == SHIFT) && sreg[WORD_W-1];
            hit_cnt <= (state == CLR) ? '0 : hit_nxt;
            bit_idx <= (state == SHIFT) ? bit_idx + 1'b1 : '0;
            if (start) begin
                grant <= pick;
                sreg <= pick ? req_word1 : req_word0;
            end else if (state_nxt == SHIFT) begin
                sreg <= sreg << 1;
            end
            if (state == DRAIN) begin
                res_id <= grant;
                res_count <= hit_nxt;
            end
            if (state == RESULT && res_ready) last_grant <= grant;
        end
    end
endmodule

// File: tb/tb_seq1010_scan_scheduler.sv
// tb_seq1010_scan_scheduler: table-driven and random jobs against a behavioural
// 1010 detector and an arithmetic hit-count / round-robin reference.
module tb_seq1010_scan_scheduler;
    localparam int W = 8;
    logic clk = 1'b0, resetn = 1'b0;
    logic [1:0] req = 2'b00;
    logic [W-1:0] word0 = '0, word1 = '0;
    logic [1:0] ack;
    logic det_rstn, det_data, det_hit = 1'b0;
    logic res_valid, res_ready = 1'b1, res_id, busy;
    logic [3:0] res_count;
    logic [3:0] hist = 4'b0;
    logic last_g = 1'b1;
    int nchk = 0, nerr = 0;

    typedef struct {
        logic [1:0] r;
        logic [W-1:0] w0, w1;
        logic id;
        int cnt;
        int stall;
    } vec_t;
    vec_t tbl[10];

    seq1010_scan_scheduler #(.WORD_W(W)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_word0(word0), .req_word1(word1),
        .ack(ack), .det_rstn(det_rstn), .det_data(det_data), .det_hit(det_hit),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // external detector: hit one cycle after the last four bits read 1,0,1,0
    always @(posedge clk) begin
        if (!det_rstn) begin
            hist <= 4'b0;
            det_hit <= 1'b0;
        end else begin
            hist <= {hist[2:0], det_data};
            det_hit <= {hist[2:0], det_data} == 4'b1010;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_count(input logic [W-1:0] w);
        int c = 0;
        for (int j = 3; j < W; j++)
            if (4'(w >> (W - 1 - j)) == 4'b1010) c++;
        return c;
    endfunction

    task automatic job(input logic [1:0] r, input logic [W-1:0] w0, input logic [W-1:0] w1,
                       input logic eid, input int ecnt, input int stall);
        int n, lat, clr_low;
        logic bad_ack, bad_busy, bad_hold;
        logic [4:0] held;
        word0 = w0;
        word1 = w1;
        req = r;
        res_ready = (stall == 0);
        n = 0;
        while (ack == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ack == 2'b00) begin
            check("ack_seen", 0, 1);
            req = 2'b00;
            return;
        end
        check("ack_grant", int'(ack), eid ? 2 : 1);
        check("clr_at_ack", int'(det_rstn), 0);
        req[eid] = 1'b0;
        lat = 0;
        bad_ack = 1'b0;
        bad_busy = 1'b0;
        clr_low = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            bad_ack = bad_ack | (ack != 2'b00);
            bad_busy = bad_busy | !busy;
            clr_low += int'(!det_rstn);
        end
        check("latency", lat, W + 2);
        check("ack_pulse", int'(bad_ack), 0);
        check("busy", int'(bad_busy), 0);
        check("clr_cycles", clr_low, 1);
        check("res_id", int'(res_id), int'(eid));
        check("res_count", int'(res_count), ecnt);
        held = {res_id, res_count};
        bad_hold = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            bad_hold = bad_hold | !res_valid | ({res_id, res_count} != held) | (ack != 2'b00);
        end
        if (stall > 0) check("backpressure_hold", int'(bad_hold), 0);
        res_ready = 1'b1;
        @(negedge clk);
        check("res_drop", int'(res_valid), 0);
        check("idle_after", int'(busy), 0);
        last_g = eid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

    initial begin
        logic [1:0] r;
        logic [W-1:0] a, b;
        logic eid;
        int n;
        logic bad;
        tbl[0] = '{2'b01, 8'hAA, 8'h00, 1'b0, 3, 0};
        tbl[1] = '{2'b10, 8'h00, 8'h0A, 1'b1, 1, 0};
        tbl[2] = '{2'b10, 8'h00, 8'hFF, 1'b1, 0, 0};
        tbl[3] = '{2'b10, 8'h00, 8'h50, 1'b1, 1, 0};
        tbl[4] = '{2'b11, 8'h0A, 8'hAA, 1'b0, 1, 0};
        tbl[5] = '{2'b11, 8'h0A, 8'hAA, 1'b1, 3, 0};
        tbl[6] = '{2'b11, 8'h0A, 8'hAA, 1'b0, 1, 0};
        tbl[7] = '{2'b11, 8'h0A, 8'hAA, 1'b1, 3, 0};
        tbl[8] = '{2'b01, 8'hAA, 8'h00, 1'b0, 3, 20};
        tbl[9] = '{2'b01, 8'h0A, 8'h00, 1'b0, 1, 0};

        #12;
        check("reset_outputs", int'({ack, det_rstn, det_data, res_valid, res_id, res_count, busy}), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("det_rstn_after_reset", int'(det_rstn), 1);
        check("idle_no_req", int'({ack, busy, res_valid}), 0);

        for (int i = 0; i < 10; i++)
            job(tbl[i].r, tbl[i].w0, tbl[i].w1, tbl[i].id, tbl[i].cnt, tbl[i].stall);

        for (int i = 0; i < 30; i++) begin
            r = 2'($urandom_range(1, 3));
            a = W'($urandom);
            b = W'($urandom);
            eid = (r == 2'b11) ? ~last_g : r[1];
            job(r, a, b, eid, model_count(eid ? b : a), $urandom_range(0, 3));
        end

        word0 = 8'hAA;
        req = 2'b01;
        n = 0;
        while (ack == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("midjob_ack", int'(ack), 1);
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("midjob_in_shift", int'(busy), 1);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_outputs", int'({ack, det_rstn, det_data, res_valid, res_id, res_count, busy}), 0);
        @(negedge clk);
        resetn = 1'b1;
        last_g = 1'b1;
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            bad = bad | res_valid | busy;
        end
        check("no_result_after_reset", int'(bad), 0);
        job(2'b11, 8'hAA, 8'h0A, 1'b0, 3, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
